draw_datapath: RTL and testbench

//  Shared drawing datapath; executes one instruction per start/finished handshake from the draw

---
 rtl/draw_datapath_pkg.sv | 39 +++
 rtl/lfsr32.sv | 19 +
 rtl/draw_datapath.sv | 141 ++++++++++++++
 tb/tb_draw_datapath.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/draw_datapath_pkg.sv
// rtl/draw_datapath_pkg.sv - shared constants, op codes, FSM states and LFSR step for the drawing datapath
package draw_datapath_pkg;

    localparam int X_COORD_WIDTH     = 8;
    localparam int Y_COORD_WIDTH     = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 32;
    localparam int OP_WIDTH          = 4;

    localparam int X_LSB      = 0;
    localparam int Y_LSB      = 8;
    localparam int COLOUR_LSB = 15;
    localparam int PLOT_BIT   = 18;
    localparam int OP_LSB     = 28;

    localparam int          DEFAULT_SCREEN_WIDTH  = 160;
    localparam int          DEFAULT_SCREEN_HEIGHT = 120;
    localparam logic [31:0] DEFAULT_LFSR_SEED     = 32'hACE1_2024;
    localparam logic [31:0] LFSR_MASK             = 32'h8020_0003;

    localparam logic [OP_WIDTH-1:0] OP_NOP    = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_PLOT   = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_CLEAR  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_RANDOM = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_CLEAR,
        S_DONE
    } dp_state_e;

    // Right-shifting Galois step for taps 32,22,2,1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - free-running 32-bit Galois LFSR, reloads seed on reset
module lfsr32
    import draw_datapath_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            value <= seed;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/draw_datapath.sv
// rtl/draw_datapath.sv - drawing datapath FSM: NOP/PLOT/CLEAR/RANDOM with VGA write port; option DATAPATH_BOUNDS_CHECK_EN
module draw_datapath
    import draw_datapath_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int          SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter logic [31:0] LFSR_SEED     = DEFAULT_LFSR_SEED
)
(
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start_dp,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
    output logic                         finished_dp,
    output logic [RESULT_WIDTH-1:0]      result_dp,
    output logic [X_COORD_WIDTH-1:0]     vga_x,
    output logic [Y_COORD_WIDTH-1:0]     vga_y,
    output logic [COLOUR_WIDTH-1:0]      vga_colour,
    output logic                         vga_plot
);

    localparam logic [X_COORD_WIDTH-1:0] X_LAST       = X_COORD_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_COORD_WIDTH-1:0] Y_LAST       = Y_COORD_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [RESULT_WIDTH-1:0]  CLEAR_RESULT = RESULT_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT);

    dp_state_e                r_state;
    logic                     r_start_q;
    logic                     r_plot;
    logic [COLOUR_WIDTH-1:0]  r_colour;
    logic [X_COORD_WIDTH-1:0] r_x;
    logic [Y_COORD_WIDTH-1:0] r_y;
    logic [X_COORD_WIDTH-1:0] r_clear_x;
    logic [Y_COORD_WIDTH-1:0] r_clear_y;
    logic [RESULT_WIDTH-1:0]  r_op_result;

    logic [31:0] w_lfsr;
    logic        w_start_rise;
    logic        w_in_bounds;
    logic        w_unused_rsvd;

    lfsr32 u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .seed   (LFSR_SEED),
        .value  (w_lfsr)
    );

    assign w_start_rise  = start_dp & ~r_start_q;
    assign w_unused_rsvd = ^instruction_dp[OP_LSB-1:PLOT_BIT+1];

`ifdef DATAPATH_BOUNDS_CHECK_EN
    assign w_in_bounds = (int'(r_x) < SCREEN_WIDTH) && (int'(r_y) < SCREEN_HEIGHT);
`else
    assign w_in_bounds = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_plot      <= 1'b0;
            r_colour    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_clear_x   <= '0;
            r_clear_y   <= '0;
            r_op_result <= '0;
            finished_dp <= 1'b1;
            result_dp   <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
        end else begin
            r_start_q <= start_dp;
            vga_plot  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_plot      <= instruction_dp[PLOT_BIT];
                        r_colour    <= instruction_dp[COLOUR_LSB +: COLOUR_WIDTH];
                        r_x         <= instruction_dp[X_LSB +: X_COORD_WIDTH];
                        r_y         <= instruction_dp[Y_LSB +: Y_COORD_WIDTH];
                        r_clear_x   <= '0;
                        r_clear_y   <= '0;
                        finished_dp <= 1'b0;
                        case (instruction_dp[OP_LSB +: OP_WIDTH])
                            OP_PLOT:  r_state <= S_PLOT;
                            OP_CLEAR: r_state <= S_CLEAR;
                            OP_NOP: begin
                                r_op_result <= '0;
                                r_state     <= S_DONE;
                            end
                            OP_RANDOM: begin
                                r_op_result <= w_lfsr;
                                r_state     <= S_DONE;
                            end
                            default: begin
                                r_op_result <= '1;
                                r_state     <= S_DONE;
                            end
                        endcase
                    end
                end
                S_PLOT: begin
                    vga_x       <= r_x;
                    vga_y       <= r_y;
                    vga_colour  <= r_colour;
                    vga_plot    <= r_plot & w_in_bounds;
                    r_op_result <= w_in_bounds ? '0 : RESULT_WIDTH'(1);
                    r_state     <= S_DONE;
                end
                S_CLEAR: begin
                    vga_x      <= r_clear_x;
                    vga_y      <= r_clear_y;
                    vga_colour <= r_colour;
                    vga_plot   <= 1'b1;
                    // Raster order, x fastest; the last pixel hands straight over to DONE.
                    if (r_clear_x == X_LAST) begin
                        r_clear_x <= '0;
                        if (r_clear_y == Y_LAST) begin
                            r_op_result <= CLEAR_RESULT;
                            r_state     <= S_DONE;
                        end else begin
                            r_clear_y <= r_clear_y + 1'b1;
                        end
                    end else begin
                        r_clear_x <= r_clear_x + 1'b1;
                    end
                end
                S_DONE: begin
                    finished_dp <= 1'b1;
                    result_dp   <= r_op_result;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_datapath.sv
// tb/tb_draw_datapath.sv - randomized self-checking bench for draw_datapath against a behavioural model
module tb_draw_datapath;

    localparam int          W    = 160;
    localparam int          H    = 120;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start_dp = 1'b0;
    logic [31:0] instruction_dp = 32'h0;
    logic        finished_dp;
    logic [31:0] result_dp;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    draw_datapath dut (
        .clock          (clock),
        .resetn         (resetn),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         cyc;
    } pix_t;

    pix_t        pix[$];
    int          cyc = 0;
    logic [31:0] m_lfsr;
    logic [31:0] last_snap;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [8:0] rsvd, input logic p,
                                       input logic [2:0] c, input logic [6:0] y, input logic [7:0] x);
        return {op, rsvd, p, c, y, x};
    endfunction

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        m_lfsr <= !resetn ? SEED : model_step(m_lfsr);
    end

    always @(negedge clock) begin
        pix_t p;
        if (vga_plot === 1'b1) begin
            p.x = vga_x; p.y = vga_y; p.c = vga_colour; p.cyc = cyc;
            pix.push_back(p);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one instruction with a 2-cycle start pulse and waits (bounded) for finished_dp.
    task automatic do_op(input logic [31:0] instr, output logic [31:0] res, output int lat, output int acc);
        @(negedge clock);
        start_dp = 1'b1;
        instruction_dp = instr;
        pix.delete();
        last_snap = m_lfsr;
        @(negedge clock);
        acc = cyc;
        instruction_dp = $urandom;
        check("accept_busy", finished_dp, 0);
        lat = 0;
        do begin
            @(negedge clock);
            start_dp = 1'b0;
            lat++;
        end while (finished_dp !== 1'b1 && lat < 25000);
        res = result_dp;
    endtask

    initial begin
        logic [31:0] res, r1, r2, exp;
        int          lat, acc, bad, n;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic        p;
        logic [3:0]  op;

        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_finished", finished_dp, 1);
        check("rst_plot", vga_plot, 0);
        check("rst_result", result_dp, 0);
        check("rst_vga_x", vga_x, 0);
        resetn = 1'b1;

        do_op(mk(4'd3, 9'($urandom), 1'b0, 3'd0, 7'd0, 8'd0), r1, lat, acc);
        check("rand_first_model", r1, last_snap);
        check("rand_lat", lat, 1);

        do_op(mk(4'd1, 9'd0, 1'b1, 3'b010, 7'd7, 8'd5), res, lat, acc);
        check("plot_count", pix.size(), 1);
        if (pix.size() == 1) begin
            check("plot_xyc", {pix[0].x, 1'b0, pix[0].y, 5'b0, pix[0].c}, {8'd5, 1'b0, 7'd7, 5'b0, 3'b010});
            check("plot_when", pix[0].cyc, acc + 1);
        end
        check("plot_lat", lat, 2);
        check("plot_result", res, 0);
        do_op(mk(4'd1, 9'd0, 1'b0, 3'b010, 7'd7, 8'd5), res, lat, acc);
        check("noplot_count", pix.size(), 0);

        for (int i = 0; i < 30; i++) begin
            x = 8'($urandom_range(W - 1)); y = 7'($urandom_range(H - 1));
            c = 3'($urandom); p = 1'($urandom);
            do_op(mk(4'd1, 9'($urandom), p, c, y, x), res, lat, acc);
            check("rplot_count", pix.size(), p);
            if (p && pix.size() == 1)
                check("rplot_xyc", {pix[0].x, 1'b0, pix[0].y, 5'b0, pix[0].c}, {x, 1'b0, y, 5'b0, c});
            check("rplot_lat", lat, 2);
            check("rplot_result", res, 0);
        end

        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom);
            if (op == 4'd1 || op == 4'd2) op = 4'd0;
            do_op(mk(op, 9'($urandom), 1'($urandom), 3'($urandom), 7'($urandom), 8'($urandom)), res, lat, acc);
            exp = (op == 4'd0) ? 32'h0 : (op == 4'd3) ? last_snap : 32'hFFFF_FFFF;
            check("rop_result", res, exp);
            check("rop_lat", lat, 1);
            check("rop_noplot", pix.size(), 0);
        end

        do_op(mk(4'd3, 9'd0, 1'b0, 3'd0, 7'd0, 8'd0), r1, lat, acc);
        repeat (10) @(negedge clock);
        do_op(mk(4'd3, 9'd0, 1'b0, 3'd0, 7'd0, 8'd0), r2, lat, acc);
        check("rand2_model", r2, last_snap);
        check("rand_differ", r1 != r2, 1);
        check("rand_nonzero", (r1 != 0) && (r2 != 0), 1);

        do_op(mk(4'd9, 9'd0, 1'b0, 3'd0, 7'd0, 8'd0), res, lat, acc);
        check("illegal_result", res, 32'hFFFF_FFFF);
        check("illegal_lat", lat, 1);
        do_op(mk(4'd0, 9'd0, 1'b0, 3'd0, 7'd0, 8'd0), res, lat, acc);
        check("nop_result", res, 0);

        do_op(mk(4'd1, 9'd0, 1'b1, 3'd4, 7'd3, 8'd200), res, lat, acc);
        check("oob_lat", lat, 2);
`ifdef DATAPATH_BOUNDS_CHECK_EN
        check("oob_count", pix.size(), 0);
        check("oob_result", res, 1);
`else
        check("oob_count", pix.size(), 1);
        if (pix.size() == 1) check("oob_x", pix[0].x, 200);
        check("oob_result", res, 0);
`endif

        do_op(mk(4'd2, 9'd0, 1'b0, 3'b001, 7'd55, 8'd77), res, lat, acc);
        check("clear_count", pix.size(), W * H);
        check("clear_lat", lat, W * H + 1);
        check("clear_result", res, 19200);
        bad = 0;
        for (int i = 0; i < pix.size(); i++)
            if (pix[i].x != 8'(i % W) || pix[i].y != 7'(i / W) || pix[i].c != 3'b001 || pix[i].cyc != acc + 1 + i)
                bad++;
        check("clear_raster", bad, 0);
        if (pix.size() == W * H)
            check("clear_last", {pix[W*H-1].x, 1'b0, pix[W*H-1].y}, {8'd159, 1'b0, 7'd119});

        @(negedge clock);
        start_dp = 1'b1;
        instruction_dp = mk(4'd2, 9'd0, 1'b0, 3'b111, 7'd0, 8'd0);
        pix.delete();
        @(negedge clock);
        @(negedge clock);
        start_dp = 1'b0;
        n = 0;
        while (pix.size() < 100 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("mid_reach100", pix.size(), 100);
        resetn = 1'b0;
        @(negedge clock);
        check("mid_rst_plot", vga_plot, 0);
        check("mid_rst_finished", finished_dp, 1);
        n = pix.size();
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("mid_rst_noplot", pix.size(), n);
        do_op(mk(4'd1, 9'd0, 1'b1, 3'd5, 7'd20, 8'd10), res, lat, acc);
        check("post_rst_count", pix.size(), 1);
        if (pix.size() == 1)
            check("post_rst_xyc", {pix[0].x, 1'b0, pix[0].y, 5'b0, pix[0].c}, {8'd10, 1'b0, 7'd20, 5'b0, 3'd5});
        check("post_rst_result", res, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
